// File: rtl/frame_buf_pkg.sv
// frame_buf_pkg: state encodings, polarity constants and sizing helpers for the frame buffer reader.
// Latency: none (types and constants only).
// Backpressure: none (no datapath here).
package frame_buf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;
  localparam logic ASSERT_H   = 1'b1;
  localparam logic DEASSERT_H = 1'b0;

  // Number of memory words making up one frame.
  function automatic int frame_words(input int h_res, input int v_res);
    return h_res * v_res;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_buf_fifo.sv
// frame_buf_fifo: first-word-fall-through synchronous FIFO for prefetched frame words.
// Latency: a pushed word is visible at pop_data one cycle after the push edge.
// Backpressure: push is dropped when full unless a pop happens in the same cycle; pop ignored when empty.
module frame_buf_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage array; cleared on reset so the head word reads as zero when empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_buf_reader.sv
// frame_buf_reader: walks one frame of buffer addresses and streams the returned words out with sof/eol/eof tags.
// Latency: first read one cycle after start; pixels emerge one cycle after their memory return.
// Backpressure: reads issue only while FIFO_DEPTH - fifo_count - outstanding > 0; output holds while out_ready is low.
// Build option FRAME_REPEAT_EN: start_n low in the frame_done cycle restarts the next frame without an IDLE cycle.
module frame_buf_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int H_RES      = 4,
  parameter int V_RES      = 4,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_n,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  mem_rd_en_n,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_rd_data_valid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic                  out_eof,
  output logic                  err_unexp
);

  import frame_buf_pkg::*;

  localparam int FRAME_WORDS = frame_words(H_RES, V_RES);
  localparam int CNT_W       = $clog2(FIFO_DEPTH+1);
  localparam int IW          = $clog2(FRAME_WORDS+1);
  localparam int XW          = cnt_width(H_RES);
  localparam int YW          = cnt_width(V_RES);

  localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [CNT_W:0]        DEPTH_V    = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [IW-1:0]         LAST_ISSUE = IW'(FRAME_WORDS-1);
  localparam logic [XW-1:0]         X_LAST     = XW'(H_RES-1);
  localparam logic [YW-1:0]         Y_LAST     = YW'(V_RES-1);

  state_t                state;
  state_t                state_nxt;
  logic                  frame_load;
  logic [ADDR_WIDTH-1:0] addr;
  logic [IW-1:0]         issue_cnt;
  logic [CNT_W-1:0]      outstanding;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic                  err_q;

  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [DATA_WIDTH-1:0] fifo_head;

  logic has_credit;
  logic issue;
  logic ret_ok;
  logic ret_bad;
  logic accept;
  logic at_eol;
  logic at_eof;
  logic frame_end;

  // Words already in the FIFO plus words still in flight may never exceed the FIFO size.
  assign has_credit = ({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_V;
  assign issue      = (state == FETCH) && has_credit;
  assign ret_ok     = mem_rd_data_valid && (outstanding != '0);
  assign ret_bad    = mem_rd_data_valid && (outstanding == '0);
  assign accept     = !fifo_empty && out_ready;
  assign at_eol     = (x == X_LAST);
  assign at_eof     = at_eol && (y == Y_LAST);
  // The eof word is the frame's last return, so when it is accepted nothing is outstanding and the FIFO drains empty.
  assign frame_end  = (state == DRAIN) && accept && at_eof;

  frame_buf_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ret_ok && (!fifo_full || accept)),
    .push_data (mem_rd_data),
    .pop       (accept),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; frame_load marks every entry into FETCH.
  always_comb begin
    state_nxt  = state;
    frame_load = 1'b0;
    case (state)
      IDLE: begin
        if (start_n == ASSERT_L) begin
          state_nxt  = FETCH;
          frame_load = 1'b1;
        end
      end
      FETCH: begin
        if (issue && (issue_cnt == LAST_ISSUE)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (frame_end) begin
`ifdef FRAME_REPEAT_EN
          if (start_n == ASSERT_L) begin
            state_nxt  = FETCH;
            frame_load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the current state and handshakes.
  always_comb begin
    busy        = (state != IDLE) ? ASSERT_H : DEASSERT_H;
    mem_rd_en_n = issue ? ASSERT_L : DEASSERT_L;
    frame_done  = frame_end ? ASSERT_H : DEASSERT_H;
  end

  // Read address and per-frame issue count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr      <= BASE;
      issue_cnt <= '0;
    end else if (frame_load) begin
      addr      <= BASE;
      issue_cnt <= '0;
    end else if (issue) begin
      addr      <= addr + ADDR_WIDTH'(1);
      issue_cnt <= issue_cnt + IW'(1);
    end
  end

  // Reads in flight: up on issue, down on an expected return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
    end else begin
      case ({issue, ret_ok})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Pixel position, advanced only when the downstream accepts a pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (frame_load) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      if (at_eol) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  // Sticky flag for a return arriving with no read outstanding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       err_q <= 1'b0;
    else if (ret_bad) err_q <= 1'b1;
  end

  // Tags are qualified with out_valid so they read zero while nothing is presented.
  assign out_valid   = !fifo_empty;
  assign out_data    = fifo_head;
  assign out_sof     = out_valid && (x == '0) && (y == '0);
  assign out_eol     = out_valid && at_eol;
  assign out_eof     = out_valid && at_eof;
  assign mem_rd_addr = addr;
  assign err_unexp   = err_q;

endmodule

// File: tb/tb_frame_buf_reader.sv
`timescale 1ns/1ps
module tb_frame_buf_reader;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NW = 16;
  localparam int HR = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_n = 1'b1;
  logic          busy;
  logic          frame_done;
  logic          mem_rd_en_n;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic          mem_rd_data_valid = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_sof;
  logic          out_eol;
  logic          out_eof;
  logic          err_unexp;

  frame_buf_reader dut (
    .clk               (clk),
    .reset             (reset),
    .start_n           (start_n),
    .busy              (busy),
    .frame_done        (frame_done),
    .mem_rd_en_n       (mem_rd_en_n),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_data       (mem_rd_data),
    .mem_rd_data_valid (mem_rd_data_valid),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_sof           (out_sof),
    .out_eol           (out_eol),
    .out_eof           (out_eof),
    .err_unexp         (err_unexp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          sof;
    logic          eol;
    logic          eof;
  } exp_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } ret_t;

  exp_t          sb[$];
  ret_t          rq[$];
  logic [DW-1:0] mem_model [NW];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lat_min = 1;
  int   lat_max = 1;
  bit   rdy_mode = 1'b0;
  logic rdy_fixed = 1'b1;
  bit   inj = 1'b0;
  int   iss_idx = 0;
  int   iss_total = 0;
  int   acc_cnt = 0;
  int   fd_cnt = 0;
  int   last_due = 0;
  int   max_inflight = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Memory responder and output-ready driver, acting just after each rising edge.
  initial begin
    ret_t r;
    int   d;
    forever begin
      @(posedge clk);
      #1;
      mem_rd_data_valid = 1'b0;
      mem_rd_data       = '0;
      if (!reset) begin
        rq.delete();
      end else if (inj) begin
        mem_rd_data_valid = 1'b1;
        mem_rd_data       = 32'hBAD0_0BAD;
        inj               = 1'b0;
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        mem_rd_data_valid = 1'b1;
        mem_rd_data       = r.data;
      end
      if (reset && mem_rd_en_n === 1'b0) begin
        checks++;
        if (mem_rd_addr !== AW'(iss_idx)) begin
          errors++;
          $display("FAIL rd_addr got %0d expected %0d", mem_rd_addr, iss_idx);
        end
        d = cyc + int'($urandom_range(lat_max, lat_min));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        rq.push_back('{d, mem_model[mem_rd_addr]});
        sb.push_back('{mem_model[iss_idx], iss_idx == 0, (iss_idx % HR) == HR-1, iss_idx == NW-1});
        iss_idx = (iss_idx + 1) % NW;
        iss_total++;
        if (sb.size() > max_inflight) max_inflight = sb.size();
      end
      out_ready = rdy_mode ? 1'($urandom_range(1, 0)) : rdy_fixed;
    end
  end

  // Output monitor: scoreboard compare on accept, frame_done and holding checks.
  initial begin
    exp_t        e;
    bit          stall_prev = 1'b0;
    logic [35:0] hold_v = '0;
    forever begin
      @(negedge clk);
      if (reset && stall_prev) begin
        checks++;
        if ({out_valid, out_data, out_sof, out_eol, out_eof} !== hold_v) begin
          errors++;
          $display("FAIL hold got %h expected %h", {out_valid, out_data, out_sof, out_eol, out_eof}, hold_v);
        end
      end
      stall_prev = reset && out_valid && !out_ready;
      hold_v     = {out_valid, out_data, out_sof, out_eol, out_eof};
      if (reset && out_valid && out_ready) begin
        acc_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL stray_pixel got data=%h expected no pixel", out_data);
        end else begin
          e = sb.pop_front();
          if ({out_data, out_sof, out_eol, out_eof, frame_done} !== {e.data, e.sof, e.eol, e.eof, e.eof}) begin
            errors++;
            $display("FAIL pixel got data=%h sof=%b eol=%b eof=%b done=%b expected data=%h sof=%b eol=%b eof=%b done=%b",
                     out_data, out_sof, out_eol, out_eof, frame_done, e.data, e.sof, e.eol, e.eof, e.eof);
          end
        end
      end else if (reset && frame_done) begin
        checks++;
        errors++;
        $display("FAIL frame_done got 1 expected 0 (no accept)");
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_pulse();
    @(negedge clk) start_n = 1'b0;
    @(negedge clk) start_n = 1'b1;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k = 0;
    while ((busy || sb.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout got busy=%0b pending=%0d expected busy=0 pending=0", nm, busy, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(2);
    checks++; if (mem_rd_en_n !== 1'b1) begin errors++; $display("FAIL rst_rd_en_n got %b expected 1", mem_rd_en_n); end
    checks++; if (mem_rd_addr !== '0) begin errors++; $display("FAIL rst_addr got %0d expected 0", mem_rd_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b expected 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %b expected 0", frame_done); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b expected 0", out_valid); end
    checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL rst_err got %b expected 0", err_unexp); end
    checks++; if ({out_sof, out_eol, out_eof} !== 3'b000) begin errors++; $display("FAIL rst_tags got %b expected 000", {out_sof, out_eol, out_eof}); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data got %h expected 0", out_data); end
    @(negedge clk) reset = 1'b1;
    tick(1);
  endtask

  task automatic test_single_frame();
    int a0 = acc_cnt;
    int f0 = fd_cnt;
    rdy_mode = 1'b0; rdy_fixed = 1'b1; lat_min = 1; lat_max = 1;
    start_pulse();
    wait_done("single", 200);
    checks++; if (acc_cnt - a0 != NW) begin errors++; $display("FAIL single_count got %0d expected %0d", acc_cnt - a0, NW); end
    checks++; if (fd_cnt - f0 != 1) begin errors++; $display("FAIL single_done got %0d expected 1", fd_cnt - f0); end
    checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL single_err got %b expected 0", err_unexp); end
  endtask

  task automatic test_backpressure();
    int a0 = acc_cnt;
    int i0 = iss_total;
    rdy_mode = 1'b0; rdy_fixed = 1'b0; lat_min = 3; lat_max = 3;
    start_pulse();
    tick(20);
    checks++; if (iss_total - i0 != 4) begin errors++; $display("FAIL bp_issued got %0d expected 4", iss_total - i0); end
    checks++; if (mem_rd_en_n !== 1'b1) begin errors++; $display("FAIL bp_rd_en_n got %b expected 1", mem_rd_en_n); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b expected 1", out_valid); end
    rdy_fixed = 1'b1;
    wait_done("bp", 300);
    checks++; if (acc_cnt - a0 != NW) begin errors++; $display("FAIL bp_count got %0d expected %0d", acc_cnt - a0, NW); end
    checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL bp_err got %b expected 0", err_unexp); end
  endtask

  task automatic test_random();
    int a0 = acc_cnt;
    rdy_mode = 1'b1; lat_min = 1; lat_max = 5; max_inflight = 0;
    start_pulse();
    wait_done("random", 1000);
    rdy_mode = 1'b0; rdy_fixed = 1'b1;
    checks++; if (acc_cnt - a0 != NW) begin errors++; $display("FAIL rand_count got %0d expected %0d", acc_cnt - a0, NW); end
    checks++; if (max_inflight > 4) begin errors++; $display("FAIL rand_inflight got %0d expected <=4", max_inflight); end
    checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL rand_err got %b expected 0", err_unexp); end
  endtask

  task automatic test_unexpected();
    @(negedge clk) inj = 1'b1;
    tick(3);
    checks++; if (err_unexp !== 1'b1) begin errors++; $display("FAIL unexp_err got %b expected 1", err_unexp); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL unexp_valid got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL unexp_busy got %b expected 0", busy); end
    tick(2);
    checks++; if (err_unexp !== 1'b1) begin errors++; $display("FAIL unexp_sticky got %b expected 1", err_unexp); end
  endtask

  task automatic test_reset_mid();
    int a0 = acc_cnt;
    int k = 0;
    rdy_mode = 1'b0; rdy_fixed = 1'b1; lat_min = 1; lat_max = 1;
    start_pulse();
    while (acc_cnt - a0 < 6 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++; if (acc_cnt - a0 < 6) begin errors++; $display("FAIL mid_timeout got %0d pixels expected 6", acc_cnt - a0); end
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b expected 0", busy); end
    checks++; if (mem_rd_en_n !== 1'b1) begin errors++; $display("FAIL mid_rd_en_n got %b expected 1", mem_rd_en_n); end
    checks++; if (mem_rd_addr !== '0) begin errors++; $display("FAIL mid_addr got %0d expected 0", mem_rd_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b expected 0", out_valid); end
    checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL mid_err got %b expected 0", err_unexp); end
    checks++; if ({frame_done, out_sof, out_eol, out_eof} !== 4'b0000) begin errors++; $display("FAIL mid_tags got %b expected 0000", {frame_done, out_sof, out_eol, out_eof}); end
    sb.delete();
    iss_idx = 0;
    tick(2);
    @(negedge clk) reset = 1'b1;
    tick(1);
    a0 = acc_cnt;
    start_pulse();
    wait_done("mid_restart", 200);
    checks++; if (acc_cnt - a0 != NW) begin errors++; $display("FAIL mid_count got %0d expected %0d", acc_cnt - a0, NW); end
    checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL mid_err_after got %b expected 0", err_unexp); end
  endtask

  task automatic test_back_to_back();
    int f0 = fd_cnt;
    int fd_cyc = -1;
    int rd2_cyc = -1;
    bit saw_idle = 1'b0;
    int k = 0;
    rdy_mode = 1'b0; rdy_fixed = 1'b1; lat_min = 1; lat_max = 1;
    @(negedge clk) start_n = 1'b0;
    while (rd2_cyc < 0 && k < 300) begin
      @(negedge clk);
      k++;
      if (fd_cyc >= 0 && !busy) saw_idle = 1'b1;
      if (fd_cyc >= 0 && mem_rd_en_n === 1'b0) rd2_cyc = cyc;
      if (frame_done && fd_cyc < 0) fd_cyc = cyc;
    end
    start_n = 1'b1;
    checks++; if (rd2_cyc < 0) begin errors++; $display("FAIL b2b_timeout got no second frame expected one"); end
`ifdef FRAME_REPEAT_EN
    checks++; if (rd2_cyc != fd_cyc + 1) begin errors++; $display("FAIL b2b_gap got %0d cycles expected 1", rd2_cyc - fd_cyc); end
    checks++; if (saw_idle) begin errors++; $display("FAIL b2b_busy got busy=0 between frames expected 1"); end
`else
    checks++; if (!saw_idle) begin errors++; $display("FAIL b2b_idle got no idle cycle expected busy=0 gap"); end
`endif
    wait_done("b2b", 300);
    checks++; if (fd_cnt - f0 != 2) begin errors++; $display("FAIL b2b_frames got %0d expected 2", fd_cnt - f0); end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) mem_model[i] = {i[7:0], 24'($urandom)};
    test_reset();
    test_single_frame();
    test_backpressure();
    test_random();
    test_unexpected();
    test_reset_mid();
    test_back_to_back();
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_buf_reader.md
Name: frame_buf_reader

Overview:
- Read-side consumer for the frame buffer memory.
- On a start request it walks one frame of addresses starting at BASE_ADDR and issues active-low read strobes to the buffer memory.
- Returned words are captured in a small credit-controlled prefetch FIFO.
- FIFO contents are presented as a valid/ready pixel stream tagged with start-of-frame, end-of-line and end-of-frame markers, for the downstream display/output path.

Parameters:
- DATA_WIDTH, 32, pixel/memory word width.
- ADDR_WIDTH, 4, memory address width.
- H_RES, 4, pixels per line.
- V_RES, 4, lines per frame; H_RES*V_RES must be ≤ 2**ADDR_WIDTH - BASE_ADDR.
- BASE_ADDR, 0, first frame address.
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low reset.
- start_n  in  1  active-low frame request, sampled in IDLE.
- busy  out  1  high whenever state ≠ IDLE.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted.
- mem_rd_en_n  out  1  active-low read strobe to buffer memory.
- mem_rd_addr  out  ADDR_WIDTH  read address.
- mem_rd_data  in  DATA_WIDTH  returned read data.
- mem_rd_data_valid  in  1  active-high, in-order return strobe, arbitrary latency ≥1.
- out_valid  out  1  stream data valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_WIDTH  pixel.
- out_sof  out  1  first pixel of frame.
- out_eol  out  1  last pixel of line.
- out_eof  out  1  last pixel of frame.
- err_unexp  out  1  sticky: return seen with zero reads outstanding.

Behaviour:
- Reset (asynchronous, reset==0): state IDLE.
  - mem_rd_en_n=1, mem_rd_addr=BASE_ADDR.
  - busy=0, frame_done=0, out_valid=0, err_unexp=0.
  - FIFO empty, outstanding=0, x=0, y=0.
  - All other outputs are 0.
- States IDLE, FETCH, DRAIN:
  - IDLE → FETCH when start_n==0. Read address loads BASE_ADDR and the issue count clears.
  - FETCH: one read per cycle when credit>0, where credit = FIFO_DEPTH − fifo_count − outstanding. Drive mem_rd_en_n=0 with the current address, then address+1.
    - credit==0 → mem_rd_en_n=1 and the address is held.
    - After the H_RES*V_RES-th read issues → DRAIN.
  - DRAIN: mem_rd_en_n=1. Leave when outstanding==0, FIFO empty and the eof pixel has been accepted.
    - frame_done pulses 1 cycle in the acceptance cycle.
    - Next state is IDLE, or FETCH when the optional feature applies.
- Outstanding counter: +1 on issue, −1 on mem_rd_data_valid. Issue and return in the same cycle leave it unchanged.
  - Width $clog2(FIFO_DEPTH+1).
  - Credits guarantee the FIFO never overflows.
- Return with outstanding==0: data is dropped, err_unexp set. It stays set until reset.
- FIFO is first-word-fall-through:
  - out_valid = !empty; out_data = head entry.
  - Pop on out_valid&&out_ready.
  - Push and pop in the same cycle are legal at any fill level, including full-with-pop.
- Position counters x (0..H_RES−1) and y (0..V_RES−1) advance only on accept:
  - x wraps to 0 after H_RES−1, and y then increments.
  - y wraps to 0 after V_RES−1.
  - out_sof = (x==0 && y==0); out_eol = (x==H_RES−1); out_eof = out_eol && (y==V_RES−1).
  - Tags are combinational from x/y and are meaningful only while out_valid is high.
- Holding rule: out_valid, out_data and the tags stay stable while out_valid && !out_ready.
- Address arithmetic is modulo 2**ADDR_WIDTH; parameter constraints ensure no wrap within a frame.
- start_n is ignored outside IDLE, except as described under the optional feature.
- Reset mid-frame: immediate return to reset values. Returns already in flight after reset flag err_unexp.

Optional Feature:
FRAME_REPEAT_EN:
- Defined: in DRAIN, if start_n==0 during the frame_done cycle, go directly to FETCH with the address at BASE_ADDR and x/y=0. This gives back-to-back frames with no IDLE cycle; busy stays 1.
- Undefined: DRAIN always returns to IDLE. A new frame needs start_n==0 sampled in IDLE, giving a minimum 1-cycle gap.

Decomposition:
- Shared package frame_buf_pkg holds:
  - The state encodings IDLE/FETCH/DRAIN.
  - ASSERT_L/DEASSERT_L and ASSERT_H/DEASSERT_H polarity constants.
  - A localparam helper for the frame word count.
- One sub-module: frame_buf_fifo, a parameterised FWFT synchronous FIFO with push, pop, count, empty and full, on the same clk and reset.

Test Plan:
- Defaults, 1-cycle memory latency, out_ready=1, start_n pulsed low: 16 reads on addresses 0..15, out_data equals the memory contents in order, sof on pixel 0, eol on pixels 3/7/11/15, eof and frame_done on pixel 15, then busy=0.
- out_ready held 0 after start, 3-cycle latency: exactly 4 reads issue and then mem_rd_en_n stays 1. Raising out_ready resumes reads one per accept. No data loss, no err_unexp.
- Random out_ready (50%) with latency 1..5: output equals the full 16-word sequence, and outstanding+count never exceeds 4.
- Inject mem_rd_data_valid while IDLE: err_unexp=1, FIFO stays empty, out_valid=0.
- Assert reset at pixel 6 mid-frame: all outputs return to reset values on the same edge. A new start then produces a full frame beginning at address 0 with out_sof.
- With FRAME_REPEAT_EN and start_n held 0: the first read of frame 2 (address 0) issues in the cycle after frame_done and busy never drops. Without the macro, busy=0 for at least 1 cycle between frames.
